// File: rtl/falu_pkg.sv
// Shared FALU definitions: op codes, FP16 field layout, flag bit positions and sequencer states.
package falu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int EXP_MSB = 14;
  localparam int EXP_LSB = 10;
  localparam int MANT_W  = 10;
  localparam logic [4:0] EXP_MAX = 5'h1F;

  localparam int FLG_ZERO = 0;
  localparam int FLG_SUB  = 1;
  localparam int FLG_INF  = 2;
  localparam int FLG_NAN  = 3;
  localparam int FLG_DZ   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/fp16_classify.sv
// FP16 classifier, combinational (0 cycles): cls = {nan, inf, sub, zero}; no handshake.
module fp16_classify
  import falu_pkg::*;
(
  input  logic [15:0] val,
  output logic [3:0]  cls
);

  logic [4:0]        exp_f;
  logic [MANT_W-1:0] mant_f;
  logic              unused_sign;

  assign exp_f       = val[EXP_MSB:EXP_LSB];
  assign mant_f      = val[MANT_W-1:0];
  assign unused_sign = val[15];

  assign cls[3] = (exp_f == EXP_MAX) && (mant_f != '0);
  assign cls[2] = (exp_f == EXP_MAX) && (mant_f == '0);
  assign cls[1] = (exp_f == 5'd0)    && (mant_f != '0);
  assign cls[0] = (exp_f == 5'd0)    && (mant_f == '0);

endmodule

// File: rtl/falu_seq.sv
// FALU sequencer: registers operands, captures result WAIT_CYCLES cycles later; out_valid held until out_ready,
// a DONE handshake may accept the next request on the same edge. FALU_SEQ_STATS_EN adds stat_ops/stat_exc.
module falu_seq
  import falu_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [1:0]  in_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [1:0]  alu_op,
  input  logic [15:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [4:0]  out_flags
`ifdef FALU_SEQ_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_exc
`endif
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       cls;
  logic [4:0]       flags_nxt;
  logic             accept;

  fp16_classify u_classify (
    .val (alu_result),
    .cls (cls)
  );

  // Both signed zeros count as a zero divisor.
  assign flags_nxt = {(alu_op == OP_DIV) && (alu_b[14:0] == 15'd0), cls};

  assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      alu_a      <= 16'h0000;
      alu_b      <= 16'h0000;
      alu_op     <= OP_ADD;
      out_result <= 16'h0000;
      out_flags  <= 5'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            alu_a  <= in_a;
            alu_b  <= in_b;
            alu_op <= in_op;
            cnt    <= CNT_W'(WAIT_CYCLES - 1);
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt == '0) begin
            out_result <= alu_result;
            out_flags  <= flags_nxt;
            out_valid  <= 1'b1;
            state      <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              alu_a  <= in_a;
              alu_b  <= in_b;
              alu_op <= in_op;
              cnt    <= CNT_W'(WAIT_CYCLES - 1);
              state  <= S_EXEC;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FALU_SEQ_STATS_EN
  logic out_hs;
  logic is_exc;

  assign out_hs = (state == S_DONE) && out_ready;
  assign is_exc = out_flags[FLG_NAN] || out_flags[FLG_INF] || out_flags[FLG_DZ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops <= 16'h0000;
      stat_exc <= 16'h0000;
    end else if (out_hs) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (is_exc && (stat_exc != 16'hFFFF)) stat_exc <= stat_exc + 16'd1;
    end
  end
`endif

endmodule
